// File: rtl/counter_14_if.sv
// Control/status bundle between the divider controller and its iteration counter.
interface counter_14_if #(
    parameter int WIDTH = 4
);
    logic             sclr;
    logic             cnt_en;
    logic             co;
    logic [WIDTH-1:0] pout;

    modport master (output sclr, output cnt_en, input co, input pout);
    modport slave  (input sclr, input cnt_en, output co, output pout);
endinterface

// File: rtl/counter_14.sv
// Modulo-(LAST+1) iteration counter with terminal-count carry-out for the divider loop.
// Optional macro COUNTER14_CO_QUALIFY_EN gates co with cnt_en; the count sequence is unaffected.
module counter_14 #(
    parameter int WIDTH = 4,
    parameter int LAST  = 13
) (
    input  logic          clk,
    input  logic          rst,
    counter_14_if.slave   bus
);
    localparam logic [WIDTH-1:0] LAST_W = LAST[WIDTH-1:0];

    logic [WIDTH-1:0] pout_q;
    logic [WIDTH-1:0] pout_d;
    logic             at_last;

    // Out-of-range values also wrap to 0 so a corrupted register self-recovers.
    always_comb begin
        pout_d = pout_q;
        if (bus.sclr) begin
            pout_d = '0;
        end else if (bus.cnt_en) begin
            if (pout_q >= LAST_W) begin
                pout_d = '0;
            end else begin
                pout_d = pout_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pout_q <= '0;
        end else begin
            pout_q <= pout_d;
        end
    end

    assign at_last  = (pout_q == LAST_W);
    assign bus.pout = pout_q;

`ifdef COUNTER14_CO_QUALIFY_EN
    assign bus.co = at_last & bus.cnt_en;
`else
    assign bus.co = at_last;
`endif

endmodule

// File: tb/tb_counter_14.sv
// Self-checking bench for counter_14: directed scenarios plus randomized traffic vs. a modulo model.
module tb_counter_14;
    localparam int WIDTH = 4;
    localparam int LAST  = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    counter_14_if #(.WIDTH(WIDTH)) bus ();
    counter_14 #(.WIDTH(WIDTH), .LAST(LAST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int model = 0;

    function automatic int model_next(input logic r, input logic c, input logic e, input int cur);
        if (r || c) return 0;
        if (e)      return (cur + 1) % (LAST + 1);
        return cur;
    endfunction

    function automatic logic model_co();
`ifdef COUNTER14_CO_QUALIFY_EN
        return (model == LAST) && bus.cnt_en;
`else
        return (model == LAST);
`endif
    endfunction

    task automatic tick();
        int nxt;
        nxt = model_next(rst, bus.sclr, bus.cnt_en, model);
        @(posedge clk);
        #1;
        model = nxt;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.sclr = 1'b0; bus.cnt_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (bus.pout !== 4'd0 || bus.co !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: pout=%0d co=%0b required pout=0 co=0", bus.pout, bus.co);
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if (bus.pout !== 4'd1) begin
            bad++;
            $display("FAIL reset_first_edge: pout=%0d required 1", bus.pout);
        end
    endtask

    task automatic test_sequence();
        bus.sclr = 1'b1; bus.cnt_en = 1'b0;
        tick();
        bus.sclr = 1'b0; bus.cnt_en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++;
            if (bus.pout !== WIDTH'(k % 14) || bus.co !== ((k % 14) == 13)) begin
                bad++;
                $display("FAIL sequence_edge%0d: pout=%0d co=%0b required pout=%0d co=%0b",
                         k, bus.pout, bus.co, k % 14, (k % 14) == 13);
            end
        end
    endtask

    task automatic test_hold();
        logic co_exp;
        bus.cnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.pout !== 4'd6 || bus.co !== 1'b0) begin
                bad++;
                $display("FAIL hold_at6: pout=%0d co=%0b required pout=6 co=0", bus.pout, bus.co);
            end
        end
        bus.cnt_en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        bus.cnt_en = 1'b0;
`ifdef COUNTER14_CO_QUALIFY_EN
        co_exp = 1'b0;
`else
        co_exp = 1'b1;
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.pout !== 4'd13 || bus.co !== co_exp) begin
                bad++;
                $display("FAIL hold_at13: pout=%0d co=%0b required pout=13 co=%0b", bus.pout, bus.co, co_exp);
            end
        end
    endtask

    task automatic test_sclr();
        bus.cnt_en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        bus.cnt_en = 1'b0;
        total++;
        if (bus.pout !== 4'd6) begin
            bad++;
            $display("FAIL sclr_setup: pout=%0d required 6", bus.pout);
        end
        bus.sclr = 1'b1;
        tick();
        bus.sclr = 1'b0;
        total++;
        if (bus.pout !== 4'd0) begin
            bad++;
            $display("FAIL sclr_clear: pout=%0d required 0", bus.pout);
        end
        bus.cnt_en = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            total++;
            if (bus.pout !== WIDTH'(k)) begin
                bad++;
                $display("FAIL sclr_resume%0d: pout=%0d required %0d", k, bus.pout, k);
            end
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (bus.pout !== 4'd5) begin
            bad++;
            $display("FAIL priority_setup: pout=%0d required 5", bus.pout);
        end
        bus.sclr = 1'b1;
        tick();
        total++;
        if (bus.pout !== 4'd0) begin
            bad++;
            $display("FAIL priority_sclr_over_en: pout=%0d required 0", bus.pout);
        end
        bus.sclr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1; bus.sclr = 1'b1;
        tick();
        rst = 1'b0; bus.sclr = 1'b0;
        total++;
        if (bus.pout !== 4'd0) begin
            bad++;
            $display("FAIL priority_rst_all: pout=%0d required 0", bus.pout);
        end
    endtask

    task automatic test_midrun_reset();
        bus.cnt_en = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        total++;
        if (bus.pout !== 4'd9) begin
            bad++;
            $display("FAIL midrun_setup: pout=%0d required 9", bus.pout);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.pout !== 4'd0) begin
            bad++;
            $display("FAIL midrun_reset: pout=%0d required 0", bus.pout);
        end
        tick();
        total++;
        if (bus.pout !== 4'd1) begin
            bad++;
            $display("FAIL midrun_resume: pout=%0d required 1", bus.pout);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 49) == 0);
            bus.sclr   = ($urandom_range(0, 19) == 0);
            bus.cnt_en = ($urandom_range(0, 3) != 0);
            tick();
            bus.cnt_en = $urandom_range(0, 1);
            #1;
            total++;
            if (bus.pout !== WIDTH'(model) || bus.co !== model_co()) begin
                bad++;
                $display("FAIL random_cycle%0d: pout=%0d co=%0b required pout=%0d co=%0b",
                         i, bus.pout, bus.co, model, model_co());
            end
        end
        rst = 1'b0; bus.sclr = 1'b0; bus.cnt_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bus.sclr = 1'b0; bus.cnt_en = 1'b0;
        #2;
        test_reset();
        test_sequence();
        test_hold();
        test_sclr();
        test_priority();
        test_midrun_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
